ultrasonic_scheduler: RTL and testbench

Time-multiplexes N ultrasonic range sensors (door entry/exit) so that only one sensor fires at a time, which prevents acoustic crosstalk. For each active channel it generates the trigger pulse, measures the echo width, and applies a distance threshold with hit debouncing. It outputs a per-channel presence level and a one-cycle presence pulse. The occupancy state machine consumes these pulses in place of single-sensor interference flags.

---
 rtl/ultrasonic_scheduler_pkg.sv | 15 +
 rtl/ultrasonic_scheduler_echo_sync.sv | 27 ++
 rtl/ultrasonic_scheduler.sv | 133 +++++++++++++
 tb/tb_ultrasonic_scheduler.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_scheduler_pkg.sv
// ultrasonic_scheduler_pkg: shared FSM encoding and timing constants derived from one clock rate.
package ultrasonic_scheduler_pkg;
    localparam int CLK_HZ        = 50_000_000;
    localparam int TRIG_CYC_D    = CLK_HZ / 100_000;
    localparam int TIMEOUT_CYC_D = CLK_HZ / 100 * 3;
    localparam int GUARD_CYC_D   = CLK_HZ / 100;
    localparam int THRESH_CYC_D  = 145_000;
    localparam int TICK_1S_CYC   = CLK_HZ;

    typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_GUARD} state_t;

    function automatic int idx_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/ultrasonic_scheduler_echo_sync.sv
// ultrasonic_scheduler_echo_sync: 2-flop synchronizer with rise/fall detect on the synchronized level.
module ultrasonic_scheduler_echo_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_echo,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic r_meta, r_sync, r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_echo;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;
endmodule

// File: rtl/ultrasonic_scheduler.sv
// ultrasonic_scheduler: fires N ultrasonic sensors one at a time, measures echo width,
// and debounces near readings into per-channel presence levels and pulses.
module ultrasonic_scheduler
    import ultrasonic_scheduler_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int TRIG_CYC    = TRIG_CYC_D,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_D,
    parameter int GUARD_CYC   = GUARD_CYC_D,
    parameter int THRESH_CYC  = THRESH_CYC_D,
    parameter int HITS        = 2,
    parameter int W           = 21
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_enable,
    input  logic [N_CH-1:0] i_echo,
    output logic [N_CH-1:0] o_trigger,
    output logic [N_CH-1:0] o_presence,
    output logic [N_CH-1:0] o_presence_pulse,
    output logic [W-1:0]    o_width_out,
    output logic [2:0]      o_width_ch,
    output logic            o_width_valid,
    output logic [N_CH-1:0] o_fault
);
    localparam int CW = idx_width(N_CH);
    localparam int HW = $clog2(HITS + 1);
    localparam logic [W-1:0]  TRIG_LAST  = W'(TRIG_CYC - 1);
    localparam logic [W-1:0]  TO_LAST    = W'(TIMEOUT_CYC - 1);
    localparam logic [W-1:0]  TO_WIDTH   = W'(TIMEOUT_CYC);
    localparam logic [W-1:0]  GUARD_LAST = W'(GUARD_CYC - 1);
    localparam logic [W-1:0]  THR        = W'(THRESH_CYC);
    localparam logic [HW-1:0] HIT_MAX    = HW'(HITS);
    localparam logic [HW-1:0] HIT_SET    = HW'(HITS - 1);

    state_t            r_state, w_nxt;
    logic [W-1:0]      r_timer, w_width, r_width;
    logic [CW-1:0]     r_ch, r_wch;
    logic [N_CH-1:0]   w_lvl, w_rise, w_fall, r_presence, r_pres_d, r_fault;
    logic [HW-1:0]     r_hit [N_CH];
    logic              r_wvalid, w_trig, w_meas, w_flt;

    for (genvar g = 0; g < N_CH; g++) begin : g_sync
        ultrasonic_scheduler_echo_sync u_sync (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_echo  (i_echo[g]),
            .o_level (w_lvl[g]),
            .o_rise  (w_rise[g]),
            .o_fall  (w_fall[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nxt;
    end

    // Width is timer+1: the first MEASURE cycle already follows one high sample.
    always_comb begin
        w_nxt   = r_state;
        w_trig  = 1'b0;
        w_meas  = 1'b0;
        w_flt   = 1'b0;
        w_width = r_timer + 1'b1;
        case (r_state)
            S_IDLE: w_nxt = i_enable ? S_TRIG : S_IDLE;
            S_TRIG: begin
                if (r_timer == '0 && w_lvl[r_ch]) begin
                    w_flt = 1'b1;
                    w_nxt = S_GUARD;
                end else begin
                    w_trig = 1'b1;
                    w_nxt  = (r_timer == TRIG_LAST) ? S_WAIT_RISE : S_TRIG;
                end
            end
            S_WAIT_RISE: begin
                w_flt = !w_rise[r_ch] && r_timer == TO_LAST;
                w_nxt = w_rise[r_ch] ? S_MEASURE : (w_flt ? S_GUARD : S_WAIT_RISE);
            end
            S_MEASURE: begin
                w_flt  = !w_fall[r_ch] && r_timer == TO_LAST;
                w_meas = w_fall[r_ch] || w_flt;
                w_width = w_flt ? TO_WIDTH : r_timer + 1'b1;
                w_nxt  = w_meas ? S_GUARD : S_MEASURE;
            end
            S_GUARD: w_nxt = (r_timer != GUARD_LAST) ? S_GUARD : (i_enable ? S_TRIG : S_IDLE);
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer    <= '0;
            r_ch       <= '0;
            r_wvalid   <= 1'b0;
            r_width    <= '0;
            r_wch      <= '0;
            r_presence <= '0;
            r_pres_d   <= '0;
            r_fault    <= '0;
            for (int i = 0; i < N_CH; i++) r_hit[i] <= '0;
        end else begin
            r_timer  <= (w_nxt != r_state || r_state == S_IDLE) ? '0 : r_timer + 1'b1;
            r_wvalid <= w_meas;
            r_pres_d <= r_presence;
            if (r_state == S_GUARD && w_nxt != S_GUARD)
                r_ch <= (r_ch == CW'(N_CH - 1)) ? '0 : r_ch + 1'b1;
            if (w_meas) begin
                r_width <= w_width;
                r_wch   <= r_ch;
            end
            if (w_flt) r_fault[r_ch] <= 1'b1;
            else if (w_meas) r_fault[r_ch] <= 1'b0;
            // Any fault or far reading breaks the run of consecutive near hits.
            if (w_flt || (w_meas && w_width >= THR)) begin
                r_hit[r_ch]      <= '0;
                r_presence[r_ch] <= 1'b0;
            end else if (w_meas) begin
                r_hit[r_ch] <= (r_hit[r_ch] == HIT_MAX) ? HIT_MAX : r_hit[r_ch] + 1'b1;
                if (r_hit[r_ch] >= HIT_SET) r_presence[r_ch] <= 1'b1;
            end
        end
    end

    assign o_trigger        = w_trig ? (N_CH'(1) << r_ch) : '0;
    assign o_presence       = r_presence;
    assign o_presence_pulse = r_presence & ~r_pres_d;
    assign o_width_out      = r_width;
    assign o_width_ch       = 3'(r_wch);
    assign o_width_valid    = r_wvalid;
    assign o_fault          = r_fault;
endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// tb_ultrasonic_scheduler: scoreboard bench for the scheduler with short sim timing constants.
module tb_ultrasonic_scheduler;
    localparam int N_CH = 2, W = 21, TRIG = 4, TMO = 200, GUARD = 20, THR = 50, HITS = 2;

    logic            clk = 1'b0, rst_n = 1'b0, i_enable = 1'b0;
    logic [N_CH-1:0] i_echo = '0;
    logic [N_CH-1:0] o_trigger, o_presence, o_presence_pulse, o_fault;
    logic [W-1:0]    o_width_out;
    logic [2:0]      o_width_ch;
    logic            o_width_valid;

    typedef struct {int ch; int w;} exp_t;
    exp_t sb[$];
    int   n_tot = 0, n_bad = 0;
    int   pcnt [N_CH] = '{0, 0};

    ultrasonic_scheduler #(
        .N_CH(N_CH), .TRIG_CYC(TRIG), .TIMEOUT_CYC(TMO), .GUARD_CYC(GUARD),
        .THRESH_CYC(THR), .HITS(HITS), .W(W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_echo(i_echo),
        .o_trigger(o_trigger), .o_presence(o_presence), .o_presence_pulse(o_presence_pulse),
        .o_width_out(o_width_out), .o_width_ch(o_width_ch), .o_width_valid(o_width_valid),
        .o_fault(o_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("onehot", 64'($countones(o_trigger) <= 1), 1);
            for (int c = 0; c < N_CH; c++) if (o_presence_pulse[c]) pcnt[c]++;
            if (o_width_valid) begin
                chk("sb_nonempty", 64'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("width", 64'(o_width_out), 64'(e.w));
                    chk("width_ch", 64'(o_width_ch), 64'(e.ch));
                end
            end
        end
    end

    task automatic wait_trig(input int ch, output int cnt);
        cnt = 0;
        while (!o_trigger[ch] && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        chk("trig_seen", 64'(o_trigger[ch]), 1);
    endtask

    task automatic trig_len(input int ch, output int len);
        len = 0;
        while (o_trigger[ch] && len < 100) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic echo_pulse(input int ch, input int len);
        exp_t e;
        repeat (2) @(negedge clk);
        i_echo[ch] = 1'b1;
        e.ch = ch;
        e.w  = len < TMO ? len : TMO;
        sb.push_back(e);
        repeat (len) @(negedge clk);
        i_echo[ch] = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic scan(input int ch, input int len);
        int c, l;
        wait_trig(ch, c);
        trig_len(ch, l);
        echo_pulse(ch, len);
    endtask

    initial begin
        int c, l, hi;
        exp_t e;
        repeat (3) @(negedge clk);
        chk("rst_trig", 64'(o_trigger), 0);
        chk("rst_pres", 64'(o_presence), 0);
        chk("rst_fault", 64'(o_fault), 0);
        chk("rst_valid", 64'(o_width_valid), 0);
        chk("rst_width", 64'(o_width_out), 0);
        i_enable = 1'b1;
        rst_n = 1'b1;

        // no echoes: trigger length, timeout fault, guard gap to channel 1
        wait_trig(0, c);
        chk("start_lat", 64'(c), 1);
        trig_len(0, l);
        chk("trig_len", 64'(l), TRIG);
        repeat (198) @(negedge clk);
        chk("pre_to_f0", 64'(o_fault[0]), 0);
        repeat (4) @(negedge clk);
        chk("to_f0", 64'(o_fault[0]), 1);
        wait_trig(1, c);
        chk("guard_gap", 64'(c), 18);

        // two near readings assert presence once
        scan(0, 30);
        chk("n1_pres", 64'(o_presence[0]), 0);
        chk("n1_fault_clr", 64'(o_fault[0]), 0);
        chk("n1_f1", 64'(o_fault[1]), 1);
        scan(0, 30);
        chk("n2_pres", 64'(o_presence[0]), 1);
        chk("n2_pulse", 64'(pcnt[0]), 1);

        // far reading clears presence and the hit count
        scan(0, 80);
        chk("far_pres", 64'(o_presence[0]), 0);
        scan(0, 30);
        chk("rehit1_pres", 64'(o_presence[0]), 0);
        scan(0, 30);
        chk("rehit2_pres", 64'(o_presence[0]), 1);
        chk("rehit_pulse", 64'(pcnt[0]), 2);

        // width equal to threshold is far; over-long echo saturates
        scan(0, THR);
        chk("thr_far", 64'(o_presence[0]), 0);
        scan(0, 250);
        chk("sat_fault", 64'(o_fault[0]), 1);
        chk("sat_pres", 64'(o_presence[0]), 0);

        // echo[1] stuck high before its slot
        wait_trig(0, c);
        i_echo[1] = 1'b1;
        trig_len(0, l);
        hi = 0;
        c = 0;
        while (!o_trigger[0] && c < 2000) begin
            if (o_trigger[1]) hi++;
            @(negedge clk);
            c++;
        end
        chk("stuck_trig1", 64'(hi), 0);
        chk("stuck_f1", 64'(o_fault[1]), 1);
        chk("stuck_f0", 64'(o_fault[0]), 1);
        i_echo[1] = 1'b0;
        scan(1, 30);
        chk("f1_clr", 64'(o_fault[1]), 0);

        // enable drop mid-measurement
        wait_trig(0, c);
        trig_len(0, l);
        repeat (2) @(negedge clk);
        i_echo[0] = 1'b1;
        e.ch = 0;
        e.w  = 30;
        sb.push_back(e);
        repeat (10) @(negedge clk);
        i_enable = 1'b0;
        repeat (20) @(negedge clk);
        i_echo[0] = 1'b0;
        hi = 0;
        repeat (600) begin
            @(negedge clk);
            if (o_trigger != 0) hi++;
        end
        chk("idle_trig", 64'(hi), 0);
        chk("idle_f0", 64'(o_fault[0]), 0);
        chk("idle_sb", 64'(sb.size()), 0);

        // reset during TRIG drops trigger at once and restarts at channel 0
        i_enable = 1'b1;
        wait_trig(1, c);
        rst_n = 1'b0;
        #1;
        chk("async_trig", 64'(o_trigger), 0);
        chk("async_fault", 64'(o_fault), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_trig(0, c);
        chk("restart_lat", 64'(c), 1);
        chk("restart_ch0", 64'(o_trigger), 1);

        chk("pulse_ch1", 64'(pcnt[1]), 0);
        chk("sb_left", 64'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
